// File: rtl/lotr_pkg.sv
// Shared C2F opcode encodings, response record and widths for the gpc_4t fabric-side blocks.
package lotr_pkg;

  localparam logic [1:0] RD     = 2'b00;
  localparam logic [1:0] WR     = 2'b01;
  localparam logic [1:0] RD_RSP = 2'b10;
  localparam logic [1:0] WR_RSP = 2'b11;

  localparam int TID_W  = 2;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
  } t_c2f_rsp;

endpackage

// File: rtl/c2f_rsp_fifo.sv
// Synchronous FIFO of C2F response records; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module c2f_rsp_fifo
  import lotr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  t_c2f_rsp                 i_push_data,
  input  logic                     i_pop,
  output t_c2f_rsp                 o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  t_c2f_rsp    r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is data only; validity comes entirely from the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr[PW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/c2f_mem_responder.sv
// Fabric-side C2F responder: Q500H request capture, Q501H memory access,
// Q502H in-order tagged responses through a small FIFO with stall/overflow control.
module c2f_mem_responder
  import lotr_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int RSP_DEPTH = 4
) (
  input  logic                QClk,
  input  logic                RstQnnnL,
  input  logic                C2F_ReqValidQ500H,
  input  logic [1:0]          C2F_ReqOpcodeQ500H,
  input  logic [TID_W-1:0]    C2F_ReqThreadIDQ500H,
  input  logic [31:0]         C2F_ReqAddressQ500H,
  input  logic [DATA_W-1:0]   C2F_ReqDataQ500H,
  input  logic                RspSlotBusyQ502H,
  output logic                C2F_RspValidQ502H,
  output logic [1:0]          C2F_RspOpcodeQ502H,
  output logic [TID_W-1:0]    C2F_RspThreadIDQ502H,
  output logic [DATA_W-1:0]   C2F_RspDataQ502H,
  output logic                C2F_RspStall,
  output logic                RspOverflowErr
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CW    = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] STALL_TH_C = CW'(RSP_DEPTH - 1);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  logic              r_vld_p1;
  logic              r_wr_p1;
  logic [TID_W-1:0]  r_tid_p1;
  logic [IDX_W-1:0]  r_idx_p1;
  logic [DATA_W-1:0] r_wdata_p1;

  logic              r_stall;
  logic              r_ovf;

  logic [IDX_W-1:0]  w_req_idx;
  logic              w_unused_addr;
  logic [DATA_W-1:0] w_rd_data;
  t_c2f_rsp          w_rsp_in;
  t_c2f_rsp          w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full_unused;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;
  logic [CW-1:0]     w_cnt_base;
  logic [CW-1:0]     w_occ_next;
  logic              w_accept;
  logic              w_rsp_vld;

  assign w_req_idx     = C2F_ReqAddressQ500H[IDX_W+1:2];
  assign w_unused_addr = ^{C2F_ReqAddressQ500H[31:IDX_W+2], C2F_ReqAddressQ500H[1:0]};

  // FIFO count after this edge's push/pop, before the new request is counted.
  assign w_push     = r_vld_p1;
  assign w_pop      = ~w_fifo_empty & ~RspSlotBusyQ502H;
  assign w_cnt_base = w_fifo_count + CW'(w_push) - CW'(w_pop);
  assign w_accept   = C2F_ReqValidQ500H & (w_cnt_base < DEPTH_C);
  assign w_occ_next = w_cnt_base + CW'(w_accept);

  // ---- Q500H -> Q501H ----
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      r_vld_p1 <= 1'b0;
      r_stall  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      r_stall  <= (w_occ_next >= STALL_TH_C);
      if (C2F_ReqValidQ500H && !w_accept) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge QClk) begin
    if (w_accept) begin
      r_wr_p1    <= (C2F_ReqOpcodeQ500H == WR);
      r_tid_p1   <= C2F_ReqThreadIDQ500H;
      r_idx_p1   <= w_req_idx;
      r_wdata_p1 <= C2F_ReqDataQ500H;
    end
  end

  // ---- Q501H: memory access, response formed and pushed at the closing edge ----
  always_ff @(posedge QClk) begin
    if (r_vld_p1 && r_wr_p1) r_mem[r_idx_p1] <= r_wdata_p1;
  end

  assign w_rd_data       = r_mem[r_idx_p1];
  assign w_rsp_in.opcode = r_wr_p1 ? WR_RSP : RD_RSP;
  assign w_rsp_in.tid    = r_tid_p1;
  assign w_rsp_in.data   = r_wr_p1 ? r_wdata_p1 : w_rd_data;

  c2f_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk       (QClk),
    .i_rst_n     (RstQnnnL),
    .i_push      (w_push),
    .i_push_data (w_rsp_in),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full_unused),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // ---- Q502H: FIFO head presented when the fabric slot is free ----
  assign w_rsp_vld            = w_pop;
  assign C2F_RspValidQ502H    = w_rsp_vld;
  assign C2F_RspOpcodeQ502H   = w_rsp_vld ? w_head.opcode : 2'b00;
  assign C2F_RspThreadIDQ502H = w_rsp_vld ? w_head.tid    : '0;
  assign C2F_RspDataQ502H     = w_rsp_vld ? w_head.data   : '0;
  assign C2F_RspStall         = r_stall;
  assign RspOverflowErr       = r_ovf;

endmodule

// File: tb/tb_c2f_mem_responder.sv
// Directed self-checking bench for c2f_mem_responder (MEM_WORDS=1024, RSP_DEPTH=4).
module tb_c2f_mem_responder;
  import lotr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic [1:0]  req_op;
  logic [1:0]  req_tid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        busy;
  logic        rsp_vld;
  logic [1:0]  rsp_op;
  logic [1:0]  rsp_tid;
  logic [31:0] rsp_data;
  logic        stall;
  logic        ovf;
  logic [36:0] obs;

  int checks   = 0;
  int failures = 0;

  logic [31:0] bdat [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

  c2f_mem_responder #(.MEM_WORDS(1024), .RSP_DEPTH(4)) dut (
    .QClk                 (clk),
    .RstQnnnL             (rst_n),
    .C2F_ReqValidQ500H    (req_vld),
    .C2F_ReqOpcodeQ500H   (req_op),
    .C2F_ReqThreadIDQ500H (req_tid),
    .C2F_ReqAddressQ500H  (req_addr),
    .C2F_ReqDataQ500H     (req_data),
    .RspSlotBusyQ502H     (busy),
    .C2F_RspValidQ502H    (rsp_vld),
    .C2F_RspOpcodeQ502H   (rsp_op),
    .C2F_RspThreadIDQ502H (rsp_tid),
    .C2F_RspDataQ502H     (rsp_data),
    .C2F_RspStall         (stall),
    .RspOverflowErr       (ovf)
  );

  assign obs = {rsp_vld, rsp_op, rsp_tid, rsp_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] tid,
                       input logic [31:0] addr, input logic [31:0] data);
    req_vld  = v;
    req_op   = op;
    req_tid  = tid;
    req_addr = addr;
    req_data = data;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    busy  = 1'b0;
    idle();
    #2;
    checks++;
    if ({obs, stall, ovf} !== 39'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {obs, stall, ovf}, 39'h0);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({obs, stall, ovf} !== 39'h0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", {obs, stall, ovf}, 39'h0);
    end
  endtask

  task automatic test_basic();
    logic [36:0] exp;
    drive(1'b1, WR, 2'd1, 32'h10, 32'hCAFE_0001);
    step();
    drive(1'b1, RD, 2'd2, 32'h10, 32'h0);
    step();
    // upper and low address bits are ignored, so this aliases word 0x10
    drive(1'b1, 2'b11, 2'd3, 32'hFFF0_1013, 32'h0);
    #1;
    exp = {1'b1, WR_RSP, 2'd1, 32'hCAFE_0001};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL basic_wr_rsp got=%h exp=%h", obs, exp);
    end
    step();
    idle();
    #1;
    exp = {1'b1, RD_RSP, 2'd2, 32'hCAFE_0001};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL basic_rd_rsp got=%h exp=%h", obs, exp);
    end
    step();
    exp = {1'b1, RD_RSP, 2'd3, 32'hCAFE_0001};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL basic_alias_rd got=%h exp=%h", obs, exp);
    end
    step();
    checks++;
    if (obs !== 37'h0) begin
      failures++;
      $display("FAIL basic_idle got=%h exp=%h", obs, 37'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, WR, 2'(3 - k), 32'h40 + 32'(4 * k), bdat[k]);
      else idle();
      #1;
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL b2b_wr_stall k=%0d got=%b exp=0", k, stall);
      end
      if (k >= 2) begin
        exp = {1'b1, WR_RSP, 2'(3 - (k - 2)), bdat[k-2]};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL b2b_wr_rsp k=%0d got=%h exp=%h", k, obs, exp);
        end
      end
      step();
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, RD, 2'(k), 32'h40 + 32'(4 * k), 32'h0);
      else idle();
      #1;
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL b2b_rd_stall k=%0d got=%b exp=0", k, stall);
      end
      if (k >= 2) begin
        exp = {1'b1, RD_RSP, 2'(k - 2), bdat[k-2]};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL b2b_rd_rsp k=%0d got=%h exp=%h", k, obs, exp);
        end
      end
      step();
    end
    checks++;
    if (obs !== 37'h0) begin
      failures++;
      $display("FAIL b2b_drained got=%h exp=%h", obs, 37'h0);
    end
  endtask

  task automatic test_slot_busy();
    logic [36:0] exp;
    busy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if ({obs, stall} !== {37'h0, (k >= 3)}) begin
        failures++;
        $display("FAIL busy_hold k=%0d got=%h/%b exp=0/%b", k, obs, stall, (k >= 3));
      end
      if (k < 3 && !stall) drive(1'b1, RD, 2'(k), 32'h40 + 32'(4 * k), 32'h0);
      else idle();
      step();
    end
    busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp = (k < 3) ? {1'b1, RD_RSP, 2'(k), bdat[k]} : 37'h0;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL busy_drain k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 1) begin
        checks++;
        if (stall !== 1'b0) begin
          failures++;
          $display("FAIL busy_stall_release got=%b exp=0", stall);
        end
      end
      step();
    end
  endtask

  task automatic test_overflow();
    logic [36:0] exp;
    int nrsp;
    drive(1'b1, WR, 2'd0, 32'h90, 32'h5555_AAAA);
    step();
    idle();
    step();
    #1;
    exp = {1'b1, WR_RSP, 2'd0, 32'h5555_AAAA};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL ovf_prewrite got=%h exp=%h", obs, exp);
    end
    step();
    busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, WR, 2'(k % 4), 32'h80 + 32'(4 * k), 32'hD000_0000 + 32'(k));
      step();
    end
    idle();
    #1;
    checks++;
    if ({ovf, stall} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_flag got=%b%b exp=11", ovf, stall);
    end
    busy = 1'b0;
    nrsp = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (rsp_vld) begin
        exp = {1'b1, WR_RSP, 2'(nrsp % 4), 32'hD000_0000 + 32'(nrsp)};
        checks++;
        if (nrsp >= 4 || obs !== exp) begin
          failures++;
          $display("FAIL ovf_drain n=%0d got=%h exp=%h", nrsp, obs, exp);
        end
        nrsp++;
      end
      step();
    end
    checks++;
    if (nrsp !== 4) begin
      failures++;
      $display("FAIL ovf_rsp_count got=%0d exp=4", nrsp);
    end
    drive(1'b1, RD, 2'd1, 32'h90, 32'h0);
    step();
    idle();
    step();
    #1;
    exp = {1'b1, RD_RSP, 2'd1, 32'h5555_AAAA};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL ovf_dropped_write got=%h exp=%h", obs, exp);
    end
    step();
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", ovf);
    end
  endtask

  task automatic test_async_reset();
    logic [36:0] exp;
    busy = 1'b1;
    drive(1'b1, WR, 2'd2, 32'hA0, 32'h1111_2222);
    step();
    drive(1'b1, WR, 2'd3, 32'hA4, 32'h3333_4444);
    step();
    idle();
    step();
    step();
    busy = 1'b0;
    #1;
    exp = {1'b1, WR_RSP, 2'd2, 32'h1111_2222};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL arst_buffered got=%h exp=%h", obs, exp);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, stall, ovf} !== 39'h0) begin
      failures++;
      $display("FAIL arst_immediate got=%h exp=%h", {obs, stall, ovf}, 39'h0);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (obs !== 37'h0) begin
        failures++;
        $display("FAIL arst_stale k=%0d got=%h exp=%h", k, obs, 37'h0);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [36:0] q[$];
    logic [36:0] exp;
    logic [31:0] mdl [5];
    logic [15:0] pat;
    logic [1:0]  op;
    logic [31:0] dat;
    int issued;
    int received;
    int idx;
    pat = 16'b0110_0011_1000_1101;
    issued = 0;
    received = 0;
    for (int cyc = 0; cyc < 300 && received < 20; cyc++) begin
      busy = pat[cyc % 16];
      #1;
      if (rsp_vld) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL wrap_extra got=%h exp=none", obs);
        end else begin
          exp = q.pop_front();
          if (obs !== exp) begin
            failures++;
            $display("FAIL wrap_rsp n=%0d got=%h exp=%h", received, obs, exp);
          end
        end
        received++;
      end
      if (!stall && issued < 20) begin
        op  = (issued < 5 || issued % 2 == 0) ? WR : RD;
        idx = issued % 5;
        dat = 32'hB000_0000 + 32'(issued * 257);
        drive(1'b1, op, 2'(issued % 4), 32'h100 + 32'(4 * idx), dat);
        if (op == WR) begin
          mdl[idx] = dat;
          q.push_back({1'b1, WR_RSP, 2'(issued % 4), dat});
        end else begin
          q.push_back({1'b1, RD_RSP, 2'(issued % 4), mdl[idx]});
        end
        issued++;
      end else begin
        idle();
      end
      step();
    end
    busy = 1'b0;
    idle();
    checks++;
    if (received !== 20 || q.size() !== 0) begin
      failures++;
      $display("FAIL wrap_count got=%0d left=%0d exp=20 left=0", received, q.size());
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL wrap_no_overflow got=%b exp=0", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_slot_busy();
    test_overflow();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
